mul_share_arbiter: RTL

// Shares one pipelined signed multiplier (4-bit operands, 4-stage pipeline) between NREQ requesters.

---
 rtl/mul_share_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one pipelined signed multiplier between NREQ requesters.
// Requester IDs ride a tag pipeline so that each product comes back to its owner at a fixed latency.
module mul_share_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned INPUTSIZE = 4,
    parameter int unsigned LATENCY   = 4,
    localparam int unsigned IDW      = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*INPUTSIZE-1:0] req_a,
    input  logic [NREQ*INPUTSIZE-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [INPUTSIZE-1:0]      mul_a,
    output logic [INPUTSIZE-1:0]      mul_b,
    input  logic [2*INPUTSIZE-1:0]    mul_res,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [2*INPUTSIZE-1:0]    rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy
);

    logic [IDW-1:0]         ptr_q;
    logic [IDW-1:0]         cand;
    logic [IDW-1:0]         grant_id;
    logic                   grant_found;
    logic                   accept;
    logic [NREQ-1:0]        grant;

    logic [INPUTSIZE-1:0]   mul_a_q;
    logic [INPUTSIZE-1:0]   mul_b_q;
    // One stage beyond LATENCY: the operand register sits in front of the multiplier's own stages.
    logic [LATENCY:0]       tag_vld_q;
    logic [IDW-1:0]         tag_id_q [LATENCY+1];

    logic [NREQ-1:0]        rsp_valid_q;
    logic [2*INPUTSIZE-1:0] rsp_data_q;
    logic [IDW-1:0]         rsp_id_q;

    // Search from ptr+1 upward, wrapping, so the last winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IDW'((32'(ptr_q) + off) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign accept = en & rst_n & grant_found;

    always_comb begin
        grant = '0;
        if (accept) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= IDW'(NREQ - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            for (int unsigned k = 0; k <= LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            if (accept) begin
                mul_a_q <= req_a[grant_id*INPUTSIZE +: INPUTSIZE];
                mul_b_q <= req_b[grant_id*INPUTSIZE +: INPUTSIZE];
                ptr_q   <= grant_id;
            end else begin
                mul_a_q <= '0;
                mul_b_q <= '0;
            end

            tag_vld_q[0] <= accept;
            tag_id_q[0]  <= grant_id;
            for (int unsigned k = 1; k <= LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end

            // mul_res is only meaningful when the aligned tag is valid; otherwise hold.
            if (tag_vld_q[LATENCY]) begin
                rsp_valid_q <= NREQ'(1) << tag_id_q[LATENCY];
                rsp_data_q  <= mul_res;
                rsp_id_q    <= tag_id_q[LATENCY];
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign req_ready = grant;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule
